cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Self-checking run controller placed between the simulation/FPGA top and the single-cycle `CPU`. It sequences the CPU reset and watches `pc` and `x31` for program completion, replacing a fixed-delay bench with a parametrised pass/fail/timeout verdict. It is synthesizable, so the same block runs in simulation and on board.

## Interface
- `XLEN`, 32, width of `pc` and `x31`.
- `RESET_CYCLES`, 3, cycles `cpu_reset` is held high after a start (≥1).
- `STABLE_CYCLES`, 4, consecutive cycles with `pc` unchanged that count as halt (≥2).
- `TIMEOUT`, 1024, maximum RUN cycles before timeout (≥1; fits 32 bits).
- `PASS_VALUE`, 1, `x31` value that means the test passed.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; applies to the whole block.
- `start` input 1: single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `pc` input XLEN: CPU program counter.
- `x31` input XLEN: CPU result register.
- `cpu_reset` output 1: reset driven to the CPU.
- `done` output 1: the run has finished.
- `pass` output 1: halted with `x31 == PASS_VALUE`.
- `timeout` output 1: no halt seen within TIMEOUT cycles.
- `cycle_count` output 32: number of RUN cycles in the current or last run.

## Operation
- FSM states: IDLE, HOLD, RUN, DONE.
- Reset:
  - State goes to IDLE.
  - `cpu_reset`=1; `done`=0, `pass`=0, `timeout`=0, `cycle_count`=0.
  - Hold counter and stable counter = 0; `pc_q`=0.
- IDLE:
  - `cpu_reset`=1.
  - `start` → HOLD, hold counter loaded with RESET_CYCLES-1.
- HOLD:
  - `cpu_reset`=1. The counter decrements each cycle.
  - At 0 → RUN. `cycle_count`, the stable counter and all flags clear.
  - `start` is ignored.
- RUN:
  - `cpu_reset`=0. `cycle_count` increments each cycle.
  - `pc_q` <= `pc` every cycle.
  - If `pc == pc_q`, the stable counter increments; otherwise it clears. The first RUN cycle always clears it.
  - Halt is detected when the stable counter reaches STABLE_CYCLES-1 while `pc == pc_q`. The block then captures `pass` <= (`x31 == PASS_VALUE`) and moves to DONE.
  - Timeout is detected when `cycle_count == TIMEOUT-1` with no halt. The block sets `timeout`=1 and `pass`=0, then moves to DONE.
  - If halt and timeout occur in the same cycle, halt wins and `timeout`=0.
  - `start` is ignored.
- DONE:
  - `done`=1; `cpu_reset`=1 (CPU frozen); all flags and `cycle_count` hold.
  - `start` → HOLD; `done`, `pass` and `timeout` clear on entry.
- `reset` asserted in any state aborts to IDLE with the reset values above on the next edge.
- Equality compares are full XLEN width. `cycle_count` never exceeds TIMEOUT.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge n means `cpu_reset` stays high through edge n+RESET_CYCLES and first reads 0 after edge n+RESET_CYCLES.
- `done` rises one edge after the detection cycle, and `pass`/`timeout` are valid in that same cycle.
- Minimum halt latency: STABLE_CYCLES RUN cycles after `pc` stops changing, plus 1 cycle to DONE.

## Configuration
- `CPU_RUN_MONITOR_PCTRACE_EN` defined:
  - Adds a ring of the last 8 distinct `pc` values captured in RUN. A value is written only when `pc != pc_q`.
  - The write pointer wraps modulo 8 and clears on `reset` and on HOLD entry.
  - Extra ports: `trace_idx` input 3, selecting the entry (0 = most recent); `trace_pc` output XLEN, a registered 1-cycle read of that entry, 0 after reset.
  - The ring freezes in DONE.
- Macro undefined: no ring and no extra ports; behaviour is otherwise identical.

## Structure
- Package `cpu_tb_pkg`: FSM state enum, `TRACE_DEPTH`=8, `TRACE_IDX_W`=3.
- Sub-module `pc_trace_ring` (XLEN, depth 8), instantiated only under the macro.

## Test plan
- Reset held for 2 cycles then released, no `start` → `cpu_reset`=1, `done`=0, `cycle_count`=0 indefinitely.
- `start` with RESET_CYCLES=3 → `cpu_reset` high exactly 3 cycles, then 0; `cycle_count` counts 1,2,3….
- `pc` steps 0,4,8,12 then stays 12 with `x31`=1, STABLE_CYCLES=4 → `done`=1, `pass`=1, `timeout`=0, `cpu_reset`=1.
- Same run with `x31`=5 → `done`=1, `pass`=0, `timeout`=0.
- `pc` increments every cycle with TIMEOUT=16 → `done`=1, `timeout`=1, `pass`=0, `cycle_count`=16.
- `reset` pulsed mid-RUN at cycle 7 → IDLE next edge, all outputs at reset values. With the macro defined, a second run then yields `trace_pc` at `trace_idx`=0 equal to the final halted `pc`.

Source files
------------

// File: rtl/cpu_tb_pkg.sv
// Shared types and constants for the CPU run monitor and its trace ring.
package cpu_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  localparam int TRACE_DEPTH = 8;
  localparam int TRACE_IDX_W = 3;

endpackage

// File: rtl/pc_trace_ring.sv
// Ring of the last TRACE_DEPTH written pc values with a registered
// read port indexed from the most recent entry (rd_idx = 0).
module pc_trace_ring
  import cpu_tb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [TRACE_IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]        rd_data
);

  logic [XLEN-1:0]        mem_r [TRACE_DEPTH];
  logic [TRACE_IDX_W-1:0] wptr_r;
  logic [TRACE_IDX_W-1:0] rd_addr_s;

  // Newest entry sits one slot behind the write pointer; wraps modulo depth.
  always_comb begin
    rd_addr_s = wptr_r - TRACE_IDX_W'(1) - rd_idx;
  end

  // Write pointer, storage and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= '0;
      rd_data <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (clear) begin
        wptr_r <= '0;
      end else if (wr_en) begin
        mem_r[wptr_r] <= wr_data;
        wptr_r        <= wptr_r + TRACE_IDX_W'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      rd_data <= mem_r[rd_addr_s];
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for a single-cycle CPU: sequences the CPU reset, watches
// pc / x31 for a halt and reports pass, fail or timeout.
// Optional feature macro: CPU_RUN_MONITOR_PCTRACE_EN adds a ring of the
// last 8 distinct RUN-phase pc values with a registered read port.
module cpu_run_monitor
  import cpu_tb_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              RESET_CYCLES  = 3,
  parameter int              STABLE_CYCLES = 4,
  parameter int              TIMEOUT       = 1024,
  parameter logic [XLEN-1:0] PASS_VALUE    = XLEN'(1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        x31,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [31:0]            cycle_count
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
  ,
  input  logic [TRACE_IDX_W-1:0] trace_idx,
  output logic [XLEN-1:0]        trace_pc
`endif
);

  run_state_t      state_r;
  run_state_t      next_state_s;
  logic [31:0]     hold_cnt_r;
  logic [31:0]     stable_cnt_r;
  logic [XLEN-1:0] pc_q_r;
  logic            first_s;
  logic            same_s;
  logic            halt_s;
  logic            tout_s;

  // Next-state logic plus halt / timeout detection in RUN.
  always_comb begin
    next_state_s = state_r;
    halt_s       = 1'b0;
    tout_s       = 1'b0;
    // cycle_count is zeroed on RUN entry, so zero marks the first RUN cycle,
    // where pc_q still holds a stale value and must not count as stable.
    first_s      = (cycle_count == 32'd0);
    same_s       = (pc == pc_q_r) && !first_s;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_HOLD;
        else       next_state_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (hold_cnt_r == 32'd0) next_state_s = ST_RUN;
        else                     next_state_s = ST_HOLD;
      end
      ST_RUN: begin
        halt_s = same_s && (stable_cnt_r == 32'(STABLE_CYCLES - 1));
        tout_s = !halt_s && (cycle_count == 32'(TIMEOUT - 1));
        if (halt_s || tout_s) next_state_s = ST_DONE;
        else                  next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) next_state_s = ST_HOLD;
        else       next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, counters and registered verdict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= 32'd0;
      stable_cnt_r <= 32'd0;
      pc_q_r       <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= 32'd0;
    end else begin
      state_r   <= next_state_s;
      cpu_reset <= (next_state_s != ST_RUN);
      done      <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) hold_cnt_r <= 32'(RESET_CYCLES - 1);
        end
        ST_HOLD: begin
          if (hold_cnt_r == 32'd0) begin
            cycle_count  <= 32'd0;
            stable_cnt_r <= 32'd0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r - 32'd1;
          end
        end
        ST_RUN: begin
          cycle_count  <= cycle_count + 32'd1;
          pc_q_r       <= pc;
          stable_cnt_r <= same_s ? (stable_cnt_r + 32'd1) : 32'd0;
          if (halt_s) begin
            pass <= (x31 == PASS_VALUE);
          end else if (tout_s) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (start) begin
            hold_cnt_r <= 32'(RESET_CYCLES - 1);
            pass       <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        default: begin
          hold_cnt_r <= 32'd0;
        end
      endcase
    end
  end

`ifdef CPU_RUN_MONITOR_PCTRACE_EN
  logic trace_clear_s;
  logic trace_wr_s;

  // Ring restarts on every HOLD entry and records only pc changes in RUN.
  always_comb begin
    trace_clear_s = (next_state_s == ST_HOLD) && (state_r != ST_HOLD);
    trace_wr_s    = (state_r == ST_RUN) && (pc != pc_q_r);
  end

  pc_trace_ring #(
    .XLEN (XLEN)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .clear   (trace_clear_s),
    .wr_en   (trace_wr_s),
    .wr_data (pc),
    .rd_idx  (trace_idx),
    .rd_data (trace_pc)
  );
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: a history-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_cpu_run_monitor;

  localparam int RC = 3;
  localparam int SC = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [31:0] x31;
  logic        cpu_reset;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] cycle_count;
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
  logic [2:0]  trace_idx;
  logic [31:0] trace_pc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Reference model state
  int          m_phase;   // 0 idle, 1 hold, 2 run, 3 done
  int          m_hold;
  int          m_cc;
  bit          m_cpu_reset, m_done, m_pass, m_timeout;
  logic [31:0] m_hist[$];

  cpu_run_monitor #(
    .XLEN(32), .RESET_CYCLES(RC), .STABLE_CYCLES(SC), .TIMEOUT(TO), .PASS_VALUE(32'd1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .x31         (x31),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .cycle_count (cycle_count)
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
    ,
    .trace_idx   (trace_idx),
    .trace_pc    (trace_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Halt = the last SC+1 pc samples of this run are identical.
  function automatic bit halted_tail();
    int n;
    n = m_hist.size();
    if (n < SC + 1) return 1'b0;
    for (int i = 1; i <= SC; i++) begin
      if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model advanced on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_hold = 0; m_cc = 0;
      m_cpu_reset = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_hold = RC; end
        1: begin
          m_hold--;
          if (m_hold == 0) begin
            m_phase = 2; m_cc = 0; m_pass = 1'b0; m_timeout = 1'b0;
            m_cpu_reset = 1'b0; m_hist.delete();
          end
        end
        2: begin
          m_hist.push_back(pc);
          m_cc++;
          if (halted_tail()) begin
            m_pass = (x31 == 32'd1); m_done = 1'b1; m_cpu_reset = 1'b1; m_phase = 3;
          end else if (m_cc == TO) begin
            m_timeout = 1'b1; m_pass = 1'b0; m_done = 1'b1; m_cpu_reset = 1'b1; m_phase = 3;
          end
        end
        default: if (start) begin
          m_phase = 1; m_hold = RC; m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0;
        end
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_cpu_reset", {31'd0, cpu_reset}, {31'd0, m_cpu_reset});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_pass", {31'd0, pass}, {31'd0, m_pass});
      chk("model_timeout", {31'd0, timeout}, {31'd0, m_timeout});
      chk("model_cycle_count", cycle_count, 32'(m_cc));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pat(input int mode, input int k);
    case (mode)
      0:       return (k < 4) ? 32'(4 * k) : 32'd12;
      1:       return 32'(4 * k);
      default: return 32'd12;
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_cpu_reset_1", {31'd0, cpu_reset}, 32'd1);
    tick(); chk("hold_cpu_reset_2", {31'd0, cpu_reset}, 32'd1);
    tick(); chk("hold_cpu_reset_3", {31'd0, cpu_reset}, 32'd1);
    tick(); chk("run_cpu_reset_low", {31'd0, cpu_reset}, 32'd0);
  endtask

  // Drive one pattern until the model reports done; start pulsed at run cycle start_at.
  task automatic run_pattern(input int mode, input logic [31:0] xv, input int start_at);
    int k = 0;
    while (!m_done && k < 40) begin
      pc = pat(mode, k); x31 = xv;
      start = (k == start_at);
      tick();
      k++;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc = 32'd0; x31 = 32'd0;
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
    trace_idx = 3'd0;
`endif
    tick(); check_en = 1'b1;
    tick(); reset = 1'b0;
    repeat (5) tick();
    chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_cycle_count", cycle_count, 32'd0);
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
    chk("reset_trace_pc", trace_pc, 32'd0);
`endif

    // Halt with pass: pc 0,4,8,12 then 12 held.
    do_start();
    run_pattern(0, 32'd1, -1);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_pass", {31'd0, pass}, 32'd1);
    chk("halt_timeout", {31'd0, timeout}, 32'd0);
    chk("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("halt_cycle_count", cycle_count, 32'd8);
    repeat (2) tick();
    chk("done_holds_count", cycle_count, 32'd8);

    // Same run, wrong x31.
    do_start();
    run_pattern(0, 32'd5, -1);
    chk("fail_done", {31'd0, done}, 32'd1);
    chk("fail_pass", {31'd0, pass}, 32'd0);
    chk("fail_timeout", {31'd0, timeout}, 32'd0);

    // pc equal to the previous run's last pc from cycle 0: first cycle never counts.
    do_start();
    run_pattern(2, 32'd1, -1);
    chk("const_pass", {31'd0, pass}, 32'd1);
    chk("const_cycle_count", cycle_count, 32'd5);

    // Timeout with start pulsed mid-run (ignored).
    do_start();
    pc = 32'd0; tick(); chk("count_1", cycle_count, 32'd1);
    pc = 32'd4; tick(); chk("count_2", cycle_count, 32'd2);
    pc = 32'd8; tick(); chk("count_3", cycle_count, 32'd3);
    begin
      int k = 3;
      while (!m_done && k < 40) begin
        pc = pat(1, k); start = (k == 5); tick(); k++;
      end
      start = 1'b0;
    end
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_cycle_count", cycle_count, 32'd16);

    // Reset mid-run at cycle 7.
    do_start();
    for (int k = 0; k < 7; k++) begin
      pc = pat(1, k); tick();
    end
    chk("mid_cycle_count", cycle_count, 32'd7);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    chk("abort_timeout", {31'd0, timeout}, 32'd0);
    chk("abort_cycle_count", cycle_count, 32'd0);

    // Second run after the abort.
    do_start();
    run_pattern(0, 32'd1, -1);
    chk("rerun_pass", {31'd0, pass}, 32'd1);
`ifdef CPU_RUN_MONITOR_PCTRACE_EN
    trace_idx = 3'd0; tick();
    chk("trace_idx0", trace_pc, 32'd12);
    trace_idx = 3'd1; tick();
    chk("trace_idx1", trace_pc, 32'd8);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
